// File: rtl/id_stage_pipe.sv
// Decode-stage datapath: register file with MEM/WB bypass, immediate extender,
// and the ID/EX pipeline register with stall/flush handling and a bubble counter.
module id_stage_pipe #(
  parameter int XLEN            = 32,
  parameter int NREG            = 32,
  parameter int AW              = 5,
  parameter int NRD             = 2,
  parameter bit BUBBLE_ON_STALL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [31:0]         d_instr,
  input  logic [XLEN-1:0]     d_pc,
  input  logic [NRD*AW-1:0]   d_raddr,
  input  logic [AW-1:0]       d_dst,
  input  logic                d_ext_op,
  input  logic                stall,
  input  logic                flush,
  input  logic                f_en,
  input  logic [AW-1:0]       f_addr,
  input  logic [XLEN-1:0]     f_data,
  input  logic                w_en,
  input  logic [AW-1:0]       w_addr,
  input  logic [XLEN-1:0]     w_data,
  output logic [NRD*XLEN-1:0] d_rdata,
  output logic                e_valid,
  output logic [NRD*XLEN-1:0] e_rdata,
  output logic [31:0]         e_instr,
  output logic [AW-1:0]       e_dst,
  output logic [XLEN-1:0]     e_ext,
  output logic [XLEN-1:0]     e_pc,
  output logic [31:0]         bubble_cnt
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [XLEN-1:0]     ext_imm;

  logic                e_valid_q, e_valid_d;
  logic [NRD*XLEN-1:0] e_rdata_q, e_rdata_d;
  logic [31:0]         e_instr_q, e_instr_d;
  logic [AW-1:0]       e_dst_q, e_dst_d;
  logic [XLEN-1:0]     e_ext_q, e_ext_d;
  logic [XLEN-1:0]     e_pc_q, e_pc_d;
  logic [31:0]         bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    regs_d = regs_q;
    if (w_en && (w_addr != '0)) begin
      regs_d[w_addr] = w_data;
    end
  end

  // MEM result is younger than WB, so it wins when both target the same register.
  always_comb begin
    d_rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      if (d_raddr[k*AW +: AW] == '0) begin
        d_rdata[k*XLEN +: XLEN] = '0;
      end else if (f_en && (f_addr == d_raddr[k*AW +: AW])) begin
        d_rdata[k*XLEN +: XLEN] = f_data;
      end else if (w_en && (w_addr == d_raddr[k*AW +: AW])) begin
        d_rdata[k*XLEN +: XLEN] = w_data;
      end else begin
        d_rdata[k*XLEN +: XLEN] = regs_q[d_raddr[k*AW +: AW]];
      end
    end
  end

  assign ext_imm = d_ext_op ? {{(XLEN-16){d_instr[15]}}, d_instr[15:0]}
                            : {{(XLEN-16){1'b0}}, d_instr[15:0]};

  always_comb begin
    e_valid_d    = e_valid_q;
    e_rdata_d    = e_rdata_q;
    e_instr_d    = e_instr_q;
    e_dst_d      = e_dst_q;
    e_ext_d      = e_ext_q;
    e_pc_d       = e_pc_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush || (stall && BUBBLE_ON_STALL)) begin
      e_valid_d    = 1'b0;
      e_rdata_d    = '0;
      e_instr_d    = '0;
      e_dst_d      = '0;
      e_ext_d      = '0;
      e_pc_d       = '0;
      bubble_cnt_d = (bubble_cnt_q == 32'hFFFF_FFFF) ? bubble_cnt_q : bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      e_valid_d = d_valid;
      e_rdata_d = d_rdata;
      e_instr_d = d_instr;
      e_dst_d   = d_dst;
      e_ext_d   = ext_imm;
      e_pc_d    = d_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      e_valid_q    <= 1'b0;
      e_rdata_q    <= '0;
      e_instr_q    <= '0;
      e_dst_q      <= '0;
      e_ext_q      <= '0;
      e_pc_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      e_valid_q    <= e_valid_d;
      e_rdata_q    <= e_rdata_d;
      e_instr_q    <= e_instr_d;
      e_dst_q      <= e_dst_d;
      e_ext_q      <= e_ext_d;
      e_pc_q       <= e_pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign e_valid    = e_valid_q;
  assign e_rdata    = e_rdata_q;
  assign e_instr    = e_instr_q;
  assign e_dst      = e_dst_q;
  assign e_ext      = e_ext_q;
  assign e_pc       = e_pc_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: one instance per stall policy, both checked every cycle
// against a behavioural model, plus directed cases with literal expectations.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, d_valid, d_ext_op, stall, flush, f_en, w_en;
  logic [31:0]         d_instr;
  logic [XLEN-1:0]     d_pc, f_data, w_data;
  logic [NRD*AW-1:0]   d_raddr;
  logic [AW-1:0]       d_dst, f_addr, w_addr;

  logic [NRD*XLEN-1:0] d_rdata_b1, e_rdata_b1, d_rdata_b0, e_rdata_b0;
  logic                e_valid_b1, e_valid_b0;
  logic [31:0]         e_instr_b1, e_instr_b0, bubble_cnt_b1, bubble_cnt_b0;
  logic [AW-1:0]       e_dst_b1, e_dst_b0;
  logic [XLEN-1:0]     e_ext_b1, e_ext_b0, e_pc_b1, e_pc_b0;

  int total = 0;
  int bad   = 0;

  id_stage_pipe #(.BUBBLE_ON_STALL(1'b1)) dut_b1 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_raddr(d_raddr), .d_dst(d_dst), .d_ext_op(d_ext_op), .stall(stall), .flush(flush),
    .f_en(f_en), .f_addr(f_addr), .f_data(f_data), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .d_rdata(d_rdata_b1), .e_valid(e_valid_b1), .e_rdata(e_rdata_b1),
    .e_instr(e_instr_b1), .e_dst(e_dst_b1), .e_ext(e_ext_b1), .e_pc(e_pc_b1),
    .bubble_cnt(bubble_cnt_b1)
  );

  id_stage_pipe #(.BUBBLE_ON_STALL(1'b0)) dut_b0 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
    .d_raddr(d_raddr), .d_dst(d_dst), .d_ext_op(d_ext_op), .stall(stall), .flush(flush),
    .f_en(f_en), .f_addr(f_addr), .f_data(f_data), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .d_rdata(d_rdata_b0), .e_valid(e_valid_b0), .e_rdata(e_rdata_b0),
    .e_instr(e_instr_b0), .e_dst(e_dst_b0), .e_ext(e_ext_b0), .e_pc(e_pc_b0),
    .bubble_cnt(bubble_cnt_b0)
  );

  // Reference state; index [b] is the model for BUBBLE_ON_STALL == b.
  logic [31:0] m_regs [32];
  logic        m_ev   [2];
  logic [63:0] m_erd  [2];
  logic [31:0] m_ei   [2];
  logic [4:0]  m_ed   [2];
  logic [31:0] m_ext  [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_cnt  [2];
  bit          m_ready = 1'b0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0)                 return 32'd0;
    if (f_en && f_addr == a)       return f_data;
    if (w_en && w_addr == a)       return w_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] model_ext();
    if (d_ext_op) return {{16{d_instr[15]}}, d_instr[15:0]};
    return {16'h0000, d_instr[15:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      for (int b = 0; b < 2; b++) begin
        m_ev[b] <= 1'b0; m_erd[b] <= 64'd0; m_ei[b] <= 32'd0;
        m_ed[b] <= 5'd0; m_ext[b] <= 32'd0; m_pc[b] <= 32'd0; m_cnt[b] <= 32'd0;
      end
      m_ready <= 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (flush || (stall && b == 1)) begin
          m_ev[b] <= 1'b0; m_erd[b] <= 64'd0; m_ei[b] <= 32'd0;
          m_ed[b] <= 5'd0; m_ext[b] <= 32'd0; m_pc[b] <= 32'd0;
          m_cnt[b] <= (m_cnt[b] == 32'hFFFF_FFFF) ? m_cnt[b] : m_cnt[b] + 32'd1;
        end else if (!stall) begin
          m_ev[b]  <= d_valid;
          m_erd[b] <= {model_read(d_raddr[9:5]), model_read(d_raddr[4:0])};
          m_ei[b]  <= d_instr;
          m_ed[b]  <= d_dst;
          m_ext[b] <= model_ext();
          m_pc[b]  <= d_pc;
        end
      end
      if (w_en && w_addr != 5'd0) m_regs[w_addr] <= w_data;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      check_output("b1.d_rdata", d_rdata_b1, {model_read(d_raddr[9:5]), model_read(d_raddr[4:0])});
      check_output("b1.e_valid", 64'(e_valid_b1), 64'(m_ev[1]));
      check_output("b1.e_rdata", e_rdata_b1, m_erd[1]);
      check_output("b1.e_instr", 64'(e_instr_b1), 64'(m_ei[1]));
      check_output("b1.e_dst", 64'(e_dst_b1), 64'(m_ed[1]));
      check_output("b1.e_ext", 64'(e_ext_b1), 64'(m_ext[1]));
      check_output("b1.e_pc", 64'(e_pc_b1), 64'(m_pc[1]));
      check_output("b1.bubble_cnt", 64'(bubble_cnt_b1), 64'(m_cnt[1]));
      check_output("b0.d_rdata", d_rdata_b0, {model_read(d_raddr[9:5]), model_read(d_raddr[4:0])});
      check_output("b0.e_valid", 64'(e_valid_b0), 64'(m_ev[0]));
      check_output("b0.e_rdata", e_rdata_b0, m_erd[0]);
      check_output("b0.e_instr", 64'(e_instr_b0), 64'(m_ei[0]));
      check_output("b0.e_dst", 64'(e_dst_b0), 64'(m_ed[0]));
      check_output("b0.e_ext", 64'(e_ext_b0), 64'(m_ext[0]));
      check_output("b0.e_pc", 64'(e_pc_b0), 64'(m_pc[0]));
      check_output("b0.bubble_cnt", 64'(bubble_cnt_b0), 64'(m_cnt[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_idle();
    reset = 1'b0; d_valid = 1'b0; d_instr = '0; d_pc = '0; d_raddr = '0; d_dst = '0;
    d_ext_op = 1'b0; stall = 1'b0; flush = 1'b0; f_en = 1'b0; f_addr = '0; f_data = '0;
    w_en = 1'b0; w_addr = '0; w_data = '0;
  endtask

  task automatic apply_stimulus();
    reset    = ($urandom_range(0, 63) == 0);
    d_valid  = 1'($urandom_range(0, 1));
    d_instr  = $urandom;
    d_pc     = $urandom;
    d_raddr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
    d_dst    = AW'($urandom_range(0, 31));
    d_ext_op = 1'($urandom_range(0, 1));
    stall    = ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 7) == 0);
    f_en     = 1'($urandom_range(0, 1));
    f_addr   = AW'($urandom_range(0, 7));
    f_data   = $urandom;
    w_en     = 1'($urandom_range(0, 1));
    w_addr   = AW'($urandom_range(0, 7));
    w_data   = $urandom;
  endtask

  initial begin
    apply_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_raddr = {5'd0, 5'd5};
    @(negedge clk);
    check_output("lit.reset_rdata", d_rdata_b1, 64'd0);
    check_output("lit.reset_evalid", 64'(e_valid_b1), 64'd0);
    check_output("lit.reset_einstr", 64'(e_instr_b1), 64'd0);
    check_output("lit.reset_cnt", 64'(bubble_cnt_b1), 64'd0);

    step();
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("lit.wb_bypass", 64'(d_rdata_b1[31:0]), 64'h0000_0000_DEAD_BEEF);
    step();
    w_en = 1'b0;
    @(negedge clk);
    check_output("lit.array_read", 64'(d_rdata_b1[31:0]), 64'h0000_0000_DEAD_BEEF);

    step();
    f_en = 1'b1; f_addr = 5'd5; f_data = 32'd1;
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'd2;
    @(negedge clk);
    check_output("lit.mem_beats_wb", 64'(d_rdata_b1[31:0]), 64'd1);
    step();
    f_en = 1'b0; w_en = 1'b0;
    @(negedge clk);
    check_output("lit.wb_landed", 64'(d_rdata_b1[31:0]), 64'd2);

    step();
    d_raddr = {5'd0, 5'd0};
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF;
    f_en = 1'b1; f_addr = 5'd0; f_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check_output("lit.r0_bypass", d_rdata_b1, 64'd0);
    step();
    @(negedge clk);
    check_output("lit.r0_after_write", d_rdata_b1, 64'd0);

    step();
    w_en = 1'b0; f_en = 1'b0;
    d_instr = 32'h0000_8001; d_ext_op = 1'b1; d_valid = 1'b1;
    step();
    d_ext_op = 1'b0;
    @(negedge clk);
    check_output("lit.sign_ext", 64'(e_ext_b1), 64'h0000_0000_FFFF_8001);
    step();
    @(negedge clk);
    check_output("lit.zero_ext", 64'(e_ext_b1), 64'h0000_0000_0000_8001);

    step();
    reset = 1'b1;
    step();
    reset = 1'b0; d_valid = 1'b1; d_instr = 32'h1234_5678; stall = 1'b0; flush = 1'b0;
    step();
    stall = 1'b1;
    step(); step(); step();
    flush = 1'b1;
    @(negedge clk);
    check_output("lit.hold_instr", 64'(e_instr_b0), 64'h0000_0000_1234_5678);
    check_output("lit.hold_valid", 64'(e_valid_b0), 64'd1);
    check_output("lit.stall_cnt3", 64'(bubble_cnt_b1), 64'd3);
    check_output("lit.stall_bubble_valid", 64'(e_valid_b1), 64'd0);
    step();
    stall = 1'b0; flush = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    check_output("lit.b1_cnt4", 64'(bubble_cnt_b1), 64'd4);
    check_output("lit.b1_valid", 64'(e_valid_b1), 64'd0);
    check_output("lit.b0_cnt1", 64'(bubble_cnt_b0), 64'd1);
    check_output("lit.b0_valid", 64'(e_valid_b0), 64'd0);
    check_output("lit.b0_flushed_instr", 64'(e_instr_b0), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      apply_stimulus();
    end
    step();
    apply_idle();
    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
